rs232_rx_ctrl: RTL

RS232 receive controller: synchronizes the raw serial line, detects the start edge, times mid-bit sample points from a clock-cycle baud counter, and issues one shift-enable pulse per bit to the rx SIPO register. After ten shifts (start, 8 data LSB-first, stop) it reads back the captured frame, checks start and stop bits, and presents the data byte with a one-cycle valid strobe. It sits between the UART pin and the downstream byte consumer, with the SIPO register as its peer.

---
 rtl/rs232_pkg.sv | 15 +
 rtl/sync_2ff.sv | 31 +++
 rtl/rs232_rx_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rs232_pkg.sv
// rtl/rs232_pkg.sv - shared constants and state type for the rs232 receive path
package rs232_pkg;

    localparam int FRAME_W              = 10;
    localparam int DATA_W               = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 5208;

    typedef enum logic [1:0] {
        IDLE,
        START,
        SHIFT,
        CHECK
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-stage synchronizer for a single asynchronous input
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/rs232_rx_ctrl.sv
// rtl/rs232_rx_ctrl.sv - rs232 receive controller driving an external SIPO register
module rs232_rx_ctrl
    import rs232_pkg::*;
#(
    parameter int ClksPerBit = CLKS_PER_BIT_DEFAULT,
    parameter int Width      = FRAME_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_i,
    input  logic [Width-1:0]  frame_i,
    output logic              shift_o,
    output logic              din_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              ferr_o,
    output logic              busy_o
);

    localparam int               BaudW    = $clog2(ClksPerBit);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(ClksPerBit - 1);
    localparam logic [BaudW-1:0] BaudHalf = BaudW'(ClksPerBit / 2 - 1);
    localparam logic [3:0]       BitLast  = 4'(Width - 1);

    logic              din;
    logic              din_prev_q, din_prev_d;
    rx_state_e         state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [3:0]        bit_q, bit_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ferr_q, ferr_d;
    logic              valid_q, valid_d;
    logic              shift;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rx_i),
        .q_o   (din)
    );

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        data_d     = data_q;
        ferr_d     = ferr_q;
        valid_d    = 1'b0;
        shift      = 1'b0;
        din_prev_d = din;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (din_prev_q && !din) begin
                    state_d = START;
                end
            end
            START: begin
                // A start bit that is high again at mid-bit is treated as line noise.
                if (baud_q == BaudHalf) begin
                    baud_d = '0;
                    if (din) begin
                        state_d = IDLE;
                    end else begin
                        shift   = 1'b1;
                        bit_d   = 4'd1;
                        state_d = SHIFT;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            SHIFT: begin
                if (baud_q == BaudLast) begin
                    shift  = 1'b1;
                    baud_d = '0;
                    bit_d  = bit_q + 4'd1;
                    if (bit_q == BitLast) begin
                        state_d = CHECK;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            CHECK: begin
                // The SIPO took the stop bit on the last edge, so the frame is complete here.
                data_d  = frame_i[DATA_W:1];
                ferr_d  = (frame_i[0] != 1'b0) | (frame_i[Width-1] != 1'b1);
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            din_prev_q <= 1'b1;
            baud_q     <= '0;
            bit_q      <= '0;
            data_q     <= '0;
            ferr_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            din_prev_q <= din_prev_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            ferr_q     <= ferr_d;
            valid_q    <= valid_d;
        end
    end

    assign shift_o = shift;
    assign din_o   = din;
    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign ferr_o  = ferr_q;
    assign busy_o  = (state_q != IDLE);

endmodule
